tlk2711_tx_framer: RTL and testbench
====================================

# tlk2711_tx_framer

Parametrised transmit framer for the TLK2711 SerDes parallel interface, the successor of the fixed-pattern TLK2711 test driver. It accepts a 16-bit valid/ready payload stream and emits framed words: comma preamble, SOF, PAYLOAD_WORDS data words, checksum, EOF. Underruns are filled with comma words. It also provides loopback, K-code idle and PRBS test modes, and drives all TLK2711 control pins. It sits between the DMA/packet source and the TLK2711 TX pins in the clk domain.

## Interface
- PAYLOAD_WORDS, 32: data words per frame, 1..65535
- NUM_COMMA, 2: comma words before SOF, 1..15
- COMMA_WORD, 16'hC5BC: D5.6 msb / K28.5 lsb
- SOF_WORD, 16'hABBC: D11.5 / K28.5
- EOF_WORD, 16'hB5BC: D21.5 / K28.5
- clk  in  1  TX clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  rising edge starts the selected mode
- i_mode  in  2  0 NORM, 1 LOOP, 2 KCODE, 3 PRBS; sampled on the start edge
- i_stop  in  1  stop request, level
- o_stop_ack  out  1  one-cycle pulse when the block returns to IDLE
- s_data  in  16  payload word
- s_valid  in  1  payload valid
- s_ready  out  1  payload accept
- o_txd  out  16  TLK2711 TXD
- o_tkmsb, o_tklsb  out  1 each  K-flags for the upper/lower byte
- o_enable, o_loopen, o_prbsen, o_lckrefn, o_testen  out  1 each  TLK2711 control pins
- o_frame_cnt  out  16  count of EOFs sent, wraps at 2^16
- o_underrun  out  1  one-cycle pulse per inserted fill word

## Operation
- Top states: IDLE, FRAME, KCODE, PRBS. FRAME has sub-phases COMMA, SOF, DATA, CKSUM, EOF.
- IDLE:
  - o_txd=0, tk=00, enable=0, loopen=0, prbsen=0, testen=0, lckrefn=1.
  - Start edge (i_start=1, previous sample 0) with mode 0 or 1: go to FRAME/COMMA.
  - Mode 2: go to KCODE. Mode 3: go to PRBS.
- COMMA: send COMMA_WORD with tk=01, NUM_COMMA cycles.
- SOF: send SOF_WORD with tk=01, 1 cycle.
- DATA:
  - NORM: s_ready=1. Each accepted word is sent with tk=00 and added to the checksum.
  - Cycle with s_valid=0: send COMMA_WORD with tk=01 and pulse o_underrun. The word counter does not advance.
  - LOOP: s_ready=0. Payload is an internal 16-bit counter, cleared on entry to FRAME and incremented per data word across frames.
  - Leave DATA after PAYLOAD_WORDS counted words.
- CKSUM: send the 16-bit sum mod 2^16 of the frame's payload words with tk=00. The checksum clears at SOF.
- EOF:
  - Send EOF_WORD with tk=01 and increment o_frame_cnt.
  - Then go to COMMA, or to IDLE if a stop is pending.
- FRAME pins: enable=1, lckrefn=1, loopen=1 in LOOP, otherwise 0.
- KCODE: send COMMA_WORD with tk=01 continuously; enable=1, lckrefn=1.
- PRBS: prbsen=1, enable=1, lckrefn=1, o_txd=0, tk=00.
- Stop:
  - FRAME: i_stop sets a sticky pending flag, honoured only after EOF, so a frame is never truncated.
  - KCODE/PRBS: exit on the cycle after i_stop is sampled high.
  - o_stop_ack pulses on the first IDLE cycle after an exit.
  - i_stop in IDLE: ignored, no ack.
  - Start edges outside IDLE: ignored.
- Reset values: all outputs 0, including o_lckrefn, o_frame_cnt and s_ready. The pending-stop flag, counters and checksum are cleared.

## Timing
- All pin outputs are registered. s_ready is combinational from state only, not from s_valid.
- A word accepted on edge N appears on o_txd after edge N+1.
- First COMMA word on o_txd: 2 cycles after the start edge is sampled.
- Last payload word and the CKSUM word are in consecutive cycles.
- Frame length without underrun: NUM_COMMA+PAYLOAD_WORDS+3 cycles.
- Stop in the EOF cycle: honoured at that EOF.
- Stop and last DATA word in the same cycle: CKSUM and EOF still sent.
- Reset mid-frame: outputs 0 on the next edge; no EOF, no ack.
- PAYLOAD_WORDS=1: DATA lasts exactly 1 counted word.

## Structure
- Package tlk2711_pkg holds:
  - mode enum (NORM/LOOP/KCODE/PRBS)
  - top-state and phase enums
  - K28_5, D5_6, D11_5, D21_5 byte constants
- No sub-module is needed: one FSM with a datapath. The word counter is $clog2(PAYLOAD_WORDS+1) bits; the comma counter is 4 bits.

## Test plan
- PAYLOAD_WORDS=4, NUM_COMMA=2, NORM, s_valid held 1, data 1,2,3,4 -> o_txd C5BC, C5BC, ABBC, 0001, 0002, 0003, 0004, 000A, B5BC, then C5BC; tk 01,01,01,00,00,00,00,00,01; o_frame_cnt=1.
- Same configuration, s_valid low for 2 cycles after word 2 -> two C5BC/tk=01 fills between 0002 and 0003, o_underrun pulses twice, checksum still 000A.
- i_stop raised during DATA of frame 1 -> frame completes through B5BC, then IDLE, o_stop_ack pulses once, o_lckrefn=1, o_enable=0.
- KCODE start, then i_stop after 10 cycles -> C5BC/tk=01 throughout, IDLE 1 cycle after the stop is sampled, ack pulse; i_stop in IDLE -> no ack.
- LOOP mode, PAYLOAD_WORDS=4 -> loopen=1, payloads 0000..0003 then 0004..0007 in the next frame, s_ready=0 throughout.
- rst asserted mid-DATA -> all outputs 0 next cycle; after release, IDLE with lckrefn=1 and no ack.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared types and 8b/10b code constants for the TLK2711 transmit framer.
package tlk2711_pkg;

  typedef enum logic [1:0] {
    MODE_NORM  = 2'd0,
    MODE_LOOP  = 2'd1,
    MODE_KCODE = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_KCODE,
    ST_PRBS
  } state_e;

  typedef enum logic [2:0] {
    PH_COMMA,
    PH_SOF,
    PH_DATA,
    PH_CKSUM,
    PH_EOF
  } phase_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D11_5 = 8'hAB;
  localparam logic [7:0] D21_5 = 8'hB5;

  // Everything that leaves the block on the TLK2711 side, travelling as one bundle.
  typedef struct packed {
    logic [15:0] txd;
    logic        tkmsb;
    logic        tklsb;
    logic        enable;
    logic        loopen;
    logic        prbsen;
    logic        lckrefn;
    logic        testen;
    logic        underrun;
    logic        stop_ack;
    logic        eof;
  } pin_word_t;

endpackage

// File: rtl/tlk2711_tx_framer_if.sv
// Payload valid/ready stream into the TLK2711 transmit framer.
interface tlk2711_tx_framer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: comma preamble, SOF, payload, checksum, EOF, plus
// loopback, K-code idle and PRBS test modes driving all SerDes control pins.
module tlk2711_tx_framer
  import tlk2711_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 32,
  parameter int unsigned NUM_COMMA     = 2,
  parameter logic [15:0] COMMA_WORD    = {D5_6, K28_5},
  parameter logic [15:0] SOF_WORD      = {D11_5, K28_5},
  parameter logic [15:0] EOF_WORD      = {D21_5, K28_5}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic                 i_stop,
  output logic                 o_stop_ack,
  tlk2711_tx_framer_if.slave   s,
  output logic [15:0]          o_txd,
  output logic                 o_tkmsb,
  output logic                 o_tklsb,
  output logic                 o_enable,
  output logic                 o_loopen,
  output logic                 o_prbsen,
  output logic                 o_lckrefn,
  output logic                 o_testen,
  output logic [15:0]          o_frame_cnt,
  output logic                 o_underrun
);

  localparam int unsigned    WCW        = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(PAYLOAD_WORDS - 1);
  localparam logic [3:0]     LAST_COMMA = 4'(NUM_COMMA - 1);

  state_e         state, state_nxt;
  phase_e         phase, phase_nxt;
  mode_e          mode, mode_nxt;
  logic           start_prev;
  logic           was_active;
  logic           stop_pend, stop_pend_nxt;
  logic [3:0]     comma_cnt, comma_cnt_nxt;
  logic [WCW-1:0] word_cnt, word_cnt_nxt;
  logic [15:0]    cksum, cksum_nxt;
  logic [15:0]    loop_cnt, loop_cnt_nxt;
  logic           start_edge;
  logic           in_data;
  logic           take;
  logic [15:0]    payload;
  pin_word_t      pins_c;
  pin_word_t      pins_p0;
  logic [15:0]    frame_cnt_p0;

  assign start_edge = i_start & ~start_prev;
  assign in_data    = (state == ST_FRAME) && (phase == PH_DATA);
  assign s.s_ready  = in_data && (mode == MODE_NORM);
  assign take       = in_data && ((mode == MODE_LOOP) || s.s_valid);
  assign payload    = (mode == MODE_LOOP) ? loop_cnt : s.s_data;

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    mode_nxt       = mode;
    stop_pend_nxt  = stop_pend;
    comma_cnt_nxt  = comma_cnt;
    word_cnt_nxt   = word_cnt;
    cksum_nxt      = cksum;
    loop_cnt_nxt   = loop_cnt;
    pins_c         = '0;
    pins_c.lckrefn = 1'b1;

    case (state)
      ST_IDLE: begin
        stop_pend_nxt   = 1'b0;
        pins_c.stop_ack = was_active;
        if (start_edge) begin
          mode_nxt = mode_e'(i_mode);
          case (mode_e'(i_mode))
            MODE_KCODE: state_nxt = ST_KCODE;
            MODE_PRBS:  state_nxt = ST_PRBS;
            default: begin
              state_nxt     = ST_FRAME;
              phase_nxt     = PH_COMMA;
              comma_cnt_nxt = '0;
              loop_cnt_nxt  = '0;
            end
          endcase
        end
      end

      ST_FRAME: begin
        pins_c.enable = 1'b1;
        pins_c.loopen = (mode == MODE_LOOP);
        if (i_stop) stop_pend_nxt = 1'b1;
        case (phase)
          PH_COMMA: begin
            pins_c.txd   = COMMA_WORD;
            pins_c.tklsb = 1'b1;
            if (comma_cnt == LAST_COMMA) begin
              phase_nxt     = PH_SOF;
              comma_cnt_nxt = '0;
            end else begin
              comma_cnt_nxt = comma_cnt + 4'd1;
            end
          end
          PH_SOF: begin
            pins_c.txd   = SOF_WORD;
            pins_c.tklsb = 1'b1;
            phase_nxt    = PH_DATA;
            word_cnt_nxt = '0;
            cksum_nxt    = '0;
          end
          PH_DATA: begin
            if (take) begin
              pins_c.txd = payload;
              cksum_nxt  = cksum + payload;
              if (mode == MODE_LOOP) loop_cnt_nxt = loop_cnt + 16'd1;
              if (word_cnt == LAST_WORD) begin
                phase_nxt    = PH_CKSUM;
                word_cnt_nxt = '0;
              end else begin
                word_cnt_nxt = word_cnt + WCW'(1);
              end
            end else begin
              // Source ran dry: keep the link aligned with a comma fill.
              pins_c.txd      = COMMA_WORD;
              pins_c.tklsb    = 1'b1;
              pins_c.underrun = 1'b1;
            end
          end
          PH_CKSUM: begin
            pins_c.txd = cksum;
            phase_nxt  = PH_EOF;
          end
          PH_EOF: begin
            pins_c.txd   = EOF_WORD;
            pins_c.tklsb = 1'b1;
            pins_c.eof   = 1'b1;
            if (stop_pend || i_stop) begin
              state_nxt     = ST_IDLE;
              stop_pend_nxt = 1'b0;
            end else begin
              phase_nxt     = PH_COMMA;
              comma_cnt_nxt = '0;
            end
          end
          default: phase_nxt = PH_COMMA;
        endcase
      end

      ST_KCODE: begin
        pins_c.txd    = COMMA_WORD;
        pins_c.tklsb  = 1'b1;
        pins_c.enable = 1'b1;
        if (i_stop) state_nxt = ST_IDLE;
      end

      ST_PRBS: begin
        pins_c.prbsen = 1'b1;
        pins_c.enable = 1'b1;
        if (i_stop) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_COMMA;
      mode       <= MODE_NORM;
      start_prev <= 1'b0;
      was_active <= 1'b0;
      stop_pend  <= 1'b0;
      comma_cnt  <= '0;
      word_cnt   <= '0;
      cksum      <= '0;
      loop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      mode       <= mode_nxt;
      start_prev <= i_start;
      was_active <= (state != ST_IDLE);
      stop_pend  <= stop_pend_nxt;
      comma_cnt  <= comma_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
      cksum      <= cksum_nxt;
      loop_cnt   <= loop_cnt_nxt;
    end
  end

  // Stage p0: word selected by the FSM, frame count advanced as EOF is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_p0      <= '0;
      frame_cnt_p0 <= '0;
    end else begin
      pins_p0      <= pins_c;
      frame_cnt_p0 <= frame_cnt_p0 + 16'(pins_c.eof);
    end
  end

  // Stage p1: registered TLK2711 pins
  always_ff @(posedge clk) begin
    if (rst) begin
      o_txd       <= '0;
      o_tkmsb     <= 1'b0;
      o_tklsb     <= 1'b0;
      o_enable    <= 1'b0;
      o_loopen    <= 1'b0;
      o_prbsen    <= 1'b0;
      o_lckrefn   <= 1'b0;
      o_testen    <= 1'b0;
      o_underrun  <= 1'b0;
      o_stop_ack  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_txd       <= pins_p0.txd;
      o_tkmsb     <= pins_p0.tkmsb;
      o_tklsb     <= pins_p0.tklsb;
      o_enable    <= pins_p0.enable;
      o_loopen    <= pins_p0.loopen;
      o_prbsen    <= pins_p0.prbsen;
      o_lckrefn   <= pins_p0.lckrefn;
      o_testen    <= pins_p0.testen;
      o_underrun  <= pins_p0.underrun;
      o_stop_ack  <= pins_p0.stop_ack;
      o_frame_cnt <= frame_cnt_p0;
    end
  end

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer with PAYLOAD_WORDS=4, NUM_COMMA=2.
module tb_tlk2711_tx_framer;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_mode;
  logic        i_stop;
  logic        o_stop_ack;
  logic [15:0] o_txd;
  logic        o_tkmsb, o_tklsb;
  logic        o_enable, o_loopen, o_prbsen, o_lckrefn, o_testen;
  logic [15:0] o_frame_cnt;
  logic        o_underrun;

  int n_pass  = 0;
  int n_total = 0;

  tlk2711_tx_framer_if sif ();

  tlk2711_tx_framer #(
    .PAYLOAD_WORDS(4),
    .NUM_COMMA    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_stop     (i_stop),
    .o_stop_ack (o_stop_ack),
    .s          (sif),
    .o_txd      (o_txd),
    .o_tkmsb    (o_tkmsb),
    .o_tklsb    (o_tklsb),
    .o_enable   (o_enable),
    .o_loopen   (o_loopen),
    .o_prbsen   (o_prbsen),
    .o_lckrefn  (o_lckrefn),
    .o_testen   (o_testen),
    .o_frame_cnt(o_frame_cnt),
    .o_underrun (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_stop = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_mode = 2'd0; i_stop = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({o_txd, o_tkmsb, o_tklsb, o_enable, o_loopen, o_prbsen, o_lckrefn, o_testen,
         o_underrun, o_stop_ack, sif.s_ready} !== 26'h0 || o_frame_cnt !== 16'h0)
      $display("FAIL reset_outputs got txd=%h lck=%b en=%b cnt=%h rdy=%b exp all zero",
               o_txd, o_lckrefn, o_enable, o_frame_cnt, sif.s_ready);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (o_lckrefn !== 1'b1 || o_enable !== 1'b0 || o_stop_ack !== 1'b0 || o_txd !== 16'h0)
      $display("FAIL reset_idle got lck=%b en=%b ack=%b txd=%h exp lck=1 en=0 ack=0 txd=0000",
               o_lckrefn, o_enable, o_stop_ack, o_txd);
    else n_pass++;
  endtask

  task automatic test_norm();
    logic [15:0] exp_txd [10] = '{16'hC5BC, 16'hC5BC, 16'hABBC, 16'h0001, 16'h0002,
                                  16'h0003, 16'h0004, 16'h000A, 16'hB5BC, 16'hC5BC};
    logic [1:0]  exp_tk  [10] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                  2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    int word;
    bit hs;
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd0; i_start = 1'b1; sif.s_valid = 1'b1; word = 1; sif.s_data = 16'(word);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (hs) begin word++; sif.s_data = 16'(word); end
      if (cyc >= 3) begin
        n_total++;
        if (o_txd !== exp_txd[cyc-3] || {o_tkmsb, o_tklsb} !== exp_tk[cyc-3])
          $display("FAIL norm_word cyc=%0d got=%h/%b exp=%h/%b",
                   cyc, o_txd, {o_tkmsb, o_tklsb}, exp_txd[cyc-3], exp_tk[cyc-3]);
        else n_pass++;
      end
      if (cyc == 10 || cyc == 11) begin
        n_total++;
        if (o_frame_cnt !== ((cyc == 11) ? 16'd1 : 16'd0))
          $display("FAIL norm_frame_cnt cyc=%0d got=%0d exp=%0d", cyc, o_frame_cnt, cyc - 10);
        else n_pass++;
      end
    end
  endtask

  task automatic test_underrun();
    logic [15:0] exp_txd [11] = '{16'hC5BC, 16'hC5BC, 16'hABBC, 16'h0001, 16'h0002, 16'hC5BC,
                                  16'hC5BC, 16'h0003, 16'h0004, 16'h000A, 16'hB5BC};
    logic [1:0]  exp_tk  [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01,
                                  2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    int word;
    bit hs;
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd0; i_start = 1'b1; sif.s_valid = 1'b1; word = 1; sif.s_data = 16'(word);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (hs) begin word++; sif.s_data = 16'(word); end
      sif.s_valid = !(cyc == 6 || cyc == 7);
      if (cyc >= 3) begin
        n_total++;
        if (o_txd !== exp_txd[cyc-3] || {o_tkmsb, o_tklsb} !== exp_tk[cyc-3] ||
            o_underrun !== (cyc == 8 || cyc == 9))
          $display("FAIL underrun_word cyc=%0d got=%h/%b/u%b exp=%h/%b/u%b", cyc, o_txd,
                   {o_tkmsb, o_tklsb}, o_underrun, exp_txd[cyc-3], exp_tk[cyc-3],
                   (cyc == 8 || cyc == 9));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stop_frame();
    int word;
    int acks;
    bit hs;
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd0; i_start = 1'b1; sif.s_valid = 1'b1; word = 1; sif.s_data = 16'(word);
    acks = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_stop = (cyc == 6);
      if (hs) begin word++; sif.s_data = 16'(word); end
      if (o_stop_ack) acks++;
      if (cyc == 10 || cyc == 11) begin
        n_total++;
        if (o_txd !== ((cyc == 10) ? 16'h000A : 16'hB5BC))
          $display("FAIL stop_tail cyc=%0d got=%h exp=%h", cyc, o_txd,
                   (cyc == 10) ? 16'h000A : 16'hB5BC);
        else n_pass++;
      end
      if (cyc == 12) begin
        n_total++;
        if (o_txd !== 16'h0 || o_stop_ack !== 1'b1 || o_enable !== 1'b0 ||
            o_lckrefn !== 1'b1 || o_frame_cnt !== 16'd1 || sif.s_ready !== 1'b0)
          $display("FAIL stop_idle got txd=%h ack=%b en=%b lck=%b cnt=%0d exp 0000/1/0/1/1",
                   o_txd, o_stop_ack, o_enable, o_lckrefn, o_frame_cnt);
        else n_pass++;
      end
    end
    n_total++;
    if (acks !== 1) $display("FAIL stop_ack_count got=%0d exp=1", acks);
    else n_pass++;
  endtask

  task automatic test_kcode();
    int acks;
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd2; i_start = 1'b1;
    acks = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_stop = (cyc == 10) || (cyc >= 15 && cyc <= 17);
      if (o_stop_ack) acks++;
      if (cyc >= 3 && cyc <= 12) begin
        n_total++;
        if (o_txd !== 16'hC5BC || {o_tkmsb, o_tklsb} !== 2'b01 || o_enable !== 1'b1)
          $display("FAIL kcode_word cyc=%0d got=%h/%b en=%b exp=c5bc/01 en=1",
                   cyc, o_txd, {o_tkmsb, o_tklsb}, o_enable);
        else n_pass++;
      end
      if (cyc == 13) begin
        n_total++;
        if (o_txd !== 16'h0 || o_stop_ack !== 1'b1 || o_enable !== 1'b0 || o_lckrefn !== 1'b1)
          $display("FAIL kcode_exit got txd=%h ack=%b en=%b lck=%b exp 0000/1/0/1",
                   o_txd, o_stop_ack, o_enable, o_lckrefn);
        else n_pass++;
      end
      if (cyc == 14 || cyc >= 18) begin
        n_total++;
        if (o_stop_ack !== 1'b0) $display("FAIL kcode_no_ack cyc=%0d got=%b exp=0", cyc, o_stop_ack);
        else n_pass++;
      end
    end
    n_total++;
    if (acks !== 1) $display("FAIL kcode_ack_count got=%0d exp=1", acks);
    else n_pass++;
  endtask

  task automatic test_prbs();
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd3; i_start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_stop = (cyc == 5);
      if (cyc == 4) begin
        n_total++;
        if (o_prbsen !== 1'b1 || o_enable !== 1'b1 || o_lckrefn !== 1'b1 ||
            o_txd !== 16'h0 || {o_tkmsb, o_tklsb} !== 2'b00)
          $display("FAIL prbs_pins got prbs=%b en=%b lck=%b txd=%h exp 1/1/1/0000",
                   o_prbsen, o_enable, o_lckrefn, o_txd);
        else n_pass++;
      end
      if (cyc == 8) begin
        n_total++;
        if (o_prbsen !== 1'b0 || o_stop_ack !== 1'b1)
          $display("FAIL prbs_exit got prbs=%b ack=%b exp 0/1", o_prbsen, o_stop_ack);
        else n_pass++;
      end
    end
  endtask

  task automatic test_loop();
    logic [15:0] exp_txd [18] = '{16'hC5BC, 16'hC5BC, 16'hABBC, 16'h0000, 16'h0001, 16'h0002,
                                  16'h0003, 16'h0006, 16'hB5BC, 16'hC5BC, 16'hC5BC, 16'hABBC,
                                  16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0016, 16'hB5BC};
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd1; i_start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      n_total++;
      if (sif.s_ready !== 1'b0) $display("FAIL loop_ready cyc=%0d got=%b exp=0", cyc, sif.s_ready);
      else n_pass++;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (cyc >= 3) begin
        n_total++;
        if (o_txd !== exp_txd[cyc-3] || o_loopen !== 1'b1)
          $display("FAIL loop_word cyc=%0d got=%h loopen=%b exp=%h loopen=1",
                   cyc, o_txd, o_loopen, exp_txd[cyc-3]);
        else n_pass++;
      end
    end
    n_total++;
    if (o_frame_cnt !== 16'd2) $display("FAIL loop_frame_cnt got=%0d exp=2", o_frame_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    @(posedge clk); #1;
    i_mode = 2'd0; i_start = 1'b1; sif.s_valid = 1'b1; sif.s_data = 16'h1234;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      rst = (cyc == 7);
      if (cyc == 8) begin
        n_total++;
        if ({o_txd, o_tkmsb, o_tklsb, o_enable, o_loopen, o_prbsen, o_lckrefn, o_testen,
             o_underrun, o_stop_ack, sif.s_ready} !== 26'h0 || o_frame_cnt !== 16'h0)
          $display("FAIL midrst_outputs got txd=%h en=%b lck=%b rdy=%b exp all zero",
                   o_txd, o_enable, o_lckrefn, sif.s_ready);
        else n_pass++;
      end
      if (cyc == 10) begin
        n_total++;
        if (o_lckrefn !== 1'b1 || o_enable !== 1'b0 || o_txd !== 16'h0 || o_frame_cnt !== 16'h0)
          $display("FAIL midrst_idle got lck=%b en=%b txd=%h cnt=%0d exp 1/0/0000/0",
                   o_lckrefn, o_enable, o_txd, o_frame_cnt);
        else n_pass++;
      end
      if (cyc >= 9) begin
        n_total++;
        if (o_stop_ack !== 1'b0) $display("FAIL midrst_no_ack cyc=%0d got=%b exp=0", cyc, o_stop_ack);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_norm();
    test_underrun();
    test_stop_frame();
    test_kcode();
    test_prbs();
    test_loop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
